// File: rtl/anim_seq_if.sv
// Control and status bundle for the frame-animation sequencer.
// The master drives the vsync/control inputs and the slave drives the frame outputs.
interface anim_seq_if #(
    parameter int unsigned FRAME_W = 1,
    parameter int unsigned DIV_W   = 4
);
    logic               vsync;
    logic               enable;
    logic               restart;
    logic [1:0]         mode;
    logic [DIV_W-1:0]   div;
    logic [FRAME_W-1:0] frame;
    logic               frame_tick;
    logic               cycle_done;
    logic               busy;

    modport master (
        output vsync, enable, restart, mode, div,
        input  frame, frame_tick, cycle_done, busy
    );

    modport slave (
        input  vsync, enable, restart, mode, div,
        output frame, frame_tick, cycle_done, busy
    );
endinterface

// File: rtl/anim_seq.sv
// Vsync-paced animation frame sequencer.
// Supports loop, ping-pong and one-shot modes, with a programmable divider between vsync edges and frame steps.
module anim_seq #(
    parameter int unsigned N_FRAMES = 2,
    parameter int unsigned FRAME_W  = 1,
    parameter int unsigned DIV_W    = 4
) (
    input logic       clk_pix,
    input logic       rst,
    anim_seq_if.slave bus
);
    localparam logic [1:0] ST_FWD  = 2'd0;
    localparam logic [1:0] ST_BWD  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(N_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ONE  = FRAME_W'(1);

    logic [1:0]         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d, frame_nx;
    logic [DIV_W-1:0]   cnt_q, cnt_d, div_eff;
    logic               vsync_q;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               rise, div_hit, step;

    always_comb begin
        rise     = bus.vsync & ~vsync_q;
        div_eff  = (bus.div == '0) ? DIV_W'(1) : bus.div;
        div_hit  = cnt_q >= (div_eff - DIV_W'(1));
        state_d  = state_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        frame_nx = frame_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        step     = 1'b0;

        if (bus.restart) begin
            frame_d = '0;
            cnt_d   = '0;
            state_d = ST_FWD;
        end else if (bus.enable && rise && state_q != ST_HOLD) begin
            if (div_hit) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        if (step) begin
            unique case (bus.mode)
                2'b01: begin
                    // Ping-pong also turns around at LAST if it got there via another mode.
                    if (frame_q == LAST || (state_q == ST_BWD && frame_q != '0)) begin
                        frame_nx = frame_q - ONE;
                        if (frame_nx == '0) begin
                            state_d = ST_FWD;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_BWD;
                        end
                    end else begin
                        frame_nx = frame_q + ONE;
                        state_d  = (frame_nx == LAST) ? ST_BWD : ST_FWD;
                    end
                end
                2'b10: begin
                    if (frame_q != LAST) frame_nx = frame_q + ONE;
                    state_d = ST_FWD;
                    if (frame_nx == LAST) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    frame_nx = (frame_q == LAST) ? '0 : frame_q + ONE;
                    state_d  = ST_FWD;
                    done_d   = (frame_q == LAST);
                end
            endcase
            frame_d = frame_nx;
            tick_d  = (frame_nx != frame_q);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q <= ST_FWD;
            frame_q <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            vsync_q <= bus.vsync;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bus.frame      = frame_q;
    assign bus.frame_tick = tick_q;
    assign bus.cycle_done = done_q;
    assign bus.busy       = (state_q != ST_HOLD);
endmodule

// File: tb/tb_anim_seq.sv
// Bench for anim_seq: a 4-frame instance checked every cycle against a frame-level model,
// plus a default-parameter instance that must toggle on every vsync rise.
module tb_anim_seq;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int DW = 4;

    logic clk_pix = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_pix = ~clk_pix;

    anim_seq_if #(.FRAME_W(FW), .DIV_W(DW)) bus ();
    anim_seq_if #(.FRAME_W(1),  .DIV_W(4))  bus2 ();

    anim_seq #(.N_FRAMES(NF), .FRAME_W(FW), .DIV_W(DW)) dut (
        .clk_pix(clk_pix),
        .rst    (rst),
        .bus    (bus)
    );

    anim_seq dut2 (
        .clk_pix(clk_pix),
        .rst    (rst),
        .bus    (bus2)
    );

    assign bus2.vsync   = bus.vsync;
    assign bus2.enable  = 1'b1;
    assign bus2.restart = 1'b0;
    assign bus2.mode    = 2'b00;
    assign bus2.div     = 4'd1;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    int done_seen = 0, tick_seen = 0, done2_seen = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    // Frame-level model: position, direction, hold flag and divider progress.
    int m_frame, m_cnt;
    bit m_up, m_hold, m_vprev, m_tick, m_done;
    int s_frame;
    bit s_vprev, s_done;

    always @(posedge clk_pix) begin : model
        int d, old, nf;
        bit rise;
        if (rst) begin
            m_frame = 0; m_cnt = 0; m_up = 1; m_hold = 0; m_vprev = 0; m_tick = 0; m_done = 0;
            s_frame = 0; s_vprev = 0; s_done = 0;
        end else begin
            rise    = bus.vsync && !m_vprev;
            m_vprev = bus.vsync;
            m_tick  = 0;
            m_done  = 0;
            if (bus.restart) begin
                m_frame = 0; m_cnt = 0; m_up = 1; m_hold = 0;
            end else if (bus.enable && rise && !m_hold) begin
                d = (bus.div == 0) ? 1 : int'(bus.div);
                if (m_cnt + 1 < d) begin
                    m_cnt++;
                end else begin
                    m_cnt = 0;
                    old   = m_frame;
                    if (bus.mode == 2'd1) begin
                        if (old == NF - 1 || (!m_up && old != 0)) begin
                            nf = old - 1; m_up = (nf == 0); m_done = (nf == 0);
                        end else begin
                            nf = old + 1; m_up = (nf != NF - 1);
                        end
                    end else if (bus.mode == 2'd2) begin
                        nf   = (old < NF - 1) ? old + 1 : old;
                        m_up = 1;
                        if (nf == NF - 1) begin m_hold = 1; m_done = 1; end
                    end else begin
                        nf = (old + 1) % NF; m_up = 1; m_done = (nf == 0);
                    end
                    m_tick  = (nf != old);
                    m_frame = nf;
                end
            end
            s_done  = 0;
            if (bus.vsync && !s_vprev) begin
                s_frame = 1 - s_frame;
                s_done  = (s_frame == 0);
            end
            s_vprev = bus.vsync;
        end
    end

    always @(negedge clk_pix) begin
        if (check_en) begin
            chk("frame", int'(bus.frame), m_frame);
            chk("frame_tick", int'(bus.frame_tick), int'(m_tick));
            chk("cycle_done", int'(bus.cycle_done), int'(m_done));
            chk("busy", int'(bus.busy), int'(!m_hold));
            chk("dflt_frame", int'(bus2.frame), s_frame);
            chk("dflt_cycle_done", int'(bus2.cycle_done), int'(s_done));
            if (bus.cycle_done === 1'b1) done_seen++;
            if (bus.frame_tick === 1'b1) tick_seen++;
            if (bus2.cycle_done === 1'b1) done2_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #2;
        end
    endtask

    task automatic pulse();
        bus.vsync = 1'b1; cyc(2);
        bus.vsync = 1'b0; cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2);
        rst = 1'b0;
        done_seen = 0; tick_seen = 0; done2_seen = 0;
    endtask

    int e36[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int e37[7]  = '{1, 2, 3, 2, 1, 0, 1};
    int e35[4]  = '{1, 0, 1, 0};
    int e38[5]  = '{1, 2, 3, 3, 3};

    initial begin
        bus.vsync = 0; bus.enable = 1; bus.restart = 0; bus.mode = 2'b00; bus.div = 4'd1;
        cyc(2);
        check_en = 1;
        chk("reset_frame", int'(bus.frame), 0);
        chk("reset_busy", int'(bus.busy), 1);

        // Divide-by-3 loop
        bus.mode = 2'b00; bus.div = 4'd3; do_reset();
        for (int k = 0; k < 12; k++) begin
            pulse();
            chk("loop_div3_frame", int'(bus.frame), e36[k]);
        end
        chk("loop_div3_done_count", done_seen, 1);
        chk("loop_div3_tick_count", tick_seen, 4);

        // Ping-pong; the default instance sees the same vsync pulses
        bus.mode = 2'b01; bus.div = 4'd1; do_reset();
        for (int k = 0; k < 7; k++) begin
            pulse();
            chk("pingpong_frame", int'(bus.frame), e37[k]);
            if (k < 4) chk("dflt_toggle_frame", int'(bus2.frame), e35[k]);
            if (k == 3) chk("dflt_done_count", done2_seen, 2);
        end
        chk("pingpong_done_count", done_seen, 1);

        // One-shot, mode change in hold, restart
        bus.mode = 2'b10; do_reset();
        for (int k = 0; k < 5; k++) begin
            pulse();
            chk("oneshot_frame", int'(bus.frame), e38[k]);
        end
        chk("oneshot_done_count", done_seen, 1);
        chk("oneshot_busy", int'(bus.busy), 0);
        bus.mode = 2'b00; pulse();
        chk("hold_after_mode_change", int'(bus.frame), 3);
        chk("hold_busy", int'(bus.busy), 0);
        bus.restart = 1; cyc(1); bus.restart = 0;
        chk("restart_frame", int'(bus.frame), 0);
        chk("restart_busy", int'(bus.busy), 1);

        // Restart beats a coincident edge; enable=0 freezes
        bus.mode = 2'b00; bus.div = 4'd1; do_reset();
        pulse(); pulse();
        chk("pre_restart_frame", int'(bus.frame), 2);
        tick_seen = 0;
        bus.vsync = 1; bus.restart = 1; cyc(1); bus.restart = 0;
        chk("restart_edge_frame", int'(bus.frame), 0);
        cyc(1); bus.vsync = 0; cyc(2);
        chk("restart_edge_no_tick", tick_seen, 0);
        bus.enable = 0;
        for (int k = 0; k < 3; k++) pulse();
        chk("frozen_frame", int'(bus.frame), 0);
        bus.enable = 1; pulse();
        chk("unfrozen_frame", int'(bus.frame), 1);

        // Reset in BWD with partial divider progress
        bus.mode = 2'b01; bus.div = 4'd2; do_reset();
        for (int k = 0; k < 9; k++) pulse();
        chk("bwd_before_rst_frame", int'(bus.frame), 2);
        do_reset();
        chk("after_rst_frame", int'(bus.frame), 0);
        pulse();
        chk("first_fresh_edge_frame", int'(bus.frame), 0);
        pulse();
        chk("second_fresh_edge_frame", int'(bus.frame), 1);
        pulse(); pulse();
        chk("fwd_after_rst_frame", int'(bus.frame), 2);

        // vsync already high when reset releases
        bus.mode = 2'b00; bus.div = 4'd1;
        rst = 1; bus.vsync = 1; cyc(2); rst = 0;
        cyc(1);
        chk("vsync_high_at_reset_frame", int'(bus.frame), 1);
        bus.vsync = 0; cyc(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom % 400 == 0);
            bus.restart = ($urandom % 60 == 0);
            bus.enable  = ($urandom % 10 != 0);
            if ($urandom % 150 == 0) bus.mode = 2'($urandom % 4);
            if ($urandom % 200 == 0) bus.div = 4'($urandom % 6);
            if ($urandom % 3 == 0) bus.vsync = ~bus.vsync;
            cyc(1);
        end
        rst = 0; bus.restart = 0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
